// File: rtl/load_store_unit.sv
// Load/store unit: sits between the pipeline and the MMU. It handles byte/half/word loads
// with sign/zero extension, read-modify-write sub-word stores, and misalignment detection.
module load_store_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_w_data,
   output logic                  stall,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  misalign_err,
   output logic                  mem_valid,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_w_data,
   input  logic [DATA_WIDTH-1:0] mem_r_data,
   input  logic                  mem_ready
);

   typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_RD, WR_WAIT} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t      state;
   logic [1:0]  lat_lo;
   logic [1:0]  lat_size;
   logic        lat_unsigned;
   logic [15:0] lat_w_data;
   logic        accept;
   logic        misaligned;

   // The registered resp_valid keeps the just-completed instruction from being taken twice.
   assign stall  = req_valid && !resp_valid;
   assign accept = req_valid && !resp_valid;

   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         SZ_HALF: misaligned = req_addr[0];
         SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
         SZ_BYTE: misaligned = 1'b0;
         default: misaligned = 1'b1;
      endcase
   end

   // Select the addressed byte/half from a read word and extend it.
   function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] word,
                                                      input logic [1:0] size,
                                                      input logic [1:0] lo,
                                                      input logic uns);
      logic [DATA_WIDTH-1:0] b_sh;
      logic [DATA_WIDTH-1:0] h_sh;
      b_sh = word >> {lo, 3'b000};
      h_sh = word >> {lo[1], 4'b0000};
      case (size)
         SZ_BYTE: extract = uns ? DATA_WIDTH'(b_sh[7:0])
                                : {{(DATA_WIDTH-8){b_sh[7]}}, b_sh[7:0]};
         SZ_HALF: extract = uns ? DATA_WIDTH'(h_sh[15:0])
                                : {{(DATA_WIDTH-16){h_sh[15]}}, h_sh[15:0]};
         default: extract = word;
      endcase
   endfunction

   // Insert the store byte/half into the read word, leaving the other lanes untouched.
   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] word,
                                                    input logic [15:0] wd,
                                                    input logic [1:0] size,
                                                    input logic [1:0] lo);
      logic [DATA_WIDTH-1:0] mask;
      logic [DATA_WIDTH-1:0] val;
      if (size == SZ_BYTE) begin
         mask = DATA_WIDTH'(8'hFF) << {lo, 3'b000};
         val  = DATA_WIDTH'(wd[7:0]) << {lo, 3'b000};
      end else begin
         mask = DATA_WIDTH'(16'hFFFF) << {lo[1], 4'b0000};
         val  = DATA_WIDTH'(wd) << {lo[1], 4'b0000};
      end
      merge = (word & ~mask) | val;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         lat_lo       <= 2'b00;
         lat_size     <= 2'b00;
         lat_unsigned <= 1'b0;
         lat_w_data   <= 16'h0000;
         mem_valid    <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_w_data   <= '0;
         resp_valid   <= 1'b0;
         resp_data    <= '0;
         misalign_err <= 1'b0;
      end else begin
         mem_valid    <= 1'b0;
         resp_valid   <= 1'b0;
         misalign_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_lo       <= req_addr[1:0];
                  lat_size     <= req_size;
                  lat_unsigned <= req_unsigned;
                  lat_w_data   <= req_w_data[15:0];
                  if (misaligned) begin
                     resp_valid   <= 1'b1;
                     misalign_err <= 1'b1;
                     resp_data    <= '0;
                  end else begin
                     mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     mem_valid <= 1'b1;
                     if (!req_we) begin
                        mem_we <= 1'b0;
                        state  <= LD_WAIT;
                     end else if (req_size == SZ_WORD) begin
                        mem_we     <= 1'b1;
                        mem_w_data <= req_w_data;
                        state      <= WR_WAIT;
                     end else begin
                        mem_we <= 1'b0;
                        state  <= RMW_RD;
                     end
                  end
               end
            end
            LD_WAIT: begin
               if (mem_ready) begin
                  resp_data  <= extract(mem_r_data, lat_size, lat_lo, lat_unsigned);
                  resp_valid <= 1'b1;
                  state      <= IDLE;
               end
            end
            RMW_RD: begin
               if (mem_ready) begin
                  mem_w_data <= merge(mem_r_data, lat_w_data, lat_size, lat_lo);
                  mem_we     <= 1'b1;
                  mem_valid  <= 1'b1;
                  state      <= WR_WAIT;
               end
            end
            WR_WAIT: begin
               if (mem_ready) begin
                  resp_data  <= '0;
                  resp_valid <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
